pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_ctrl_pkg.sv | 27 ++
 rtl/freq_window_meter.sv | 49 ++++
 rtl/pll_lock_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL acquisition/lock controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LPF_RST,
        COARSE,
        SETTLE,
        TRACK,
        LOCKED,
        FAIL
    } state_e;

    localparam int WIN_DEF        = 256;
    localparam int TARGET_DEF     = 230;
    localparam int TOL_DEF        = 2;
    localparam int LOSS_TOL_DEF   = 8;
    localparam int LOCK_WINS_DEF  = 4;
    localparam int SETTLE_CYC_DEF = 64;
    localparam int RST_CYC_DEF    = 16;
    localparam int MAX_RETRY_DEF  = 3;

    localparam int         CNT_W      = 10;
    localparam int         TRACK_WINS = 32;
    localparam logic [4:0] BAND_INIT  = 5'b10000;

endpackage

// File: rtl/freq_window_meter.sv
// Back-to-back WIN-cycle measurement windows: counts fb_tick and up|down activity,
// presenting both totals (including the final cycle's inputs) with a one-cycle done.
module freq_window_meter
    import pll_ctrl_pkg::*;
#(
    parameter int WIN = WIN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             fb_tick,
    input  logic             act,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] act_count
);

    localparam int            TW   = $clog2(WIN);
    localparam logic [TW-1:0] LAST = TW'(WIN - 1);

    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] ticks;
    logic [CNT_W-1:0] acts;
    logic [CNT_W-1:0] ticks_nx;
    logic [CNT_W-1:0] acts_nx;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        ticks_nx = (fb_tick && (ticks != '1)) ? ticks + 10'd1 : ticks;
        acts_nx  = (act && (acts != '1)) ? acts + 10'd1 : acts;
    end

    assign done      = !clr && (timer == LAST);
    assign count     = ticks_nx;
    assign act_count = acts_nx;

    always_ff @(posedge clk) begin
        if (rst || clr || done) begin
            timer <= '0;
            ticks <= '0;
            acts  <= '0;
        end else begin
            timer <= timer + TW'(1);
            ticks <= ticks_nx;
            acts  <= acts_nx;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL acquisition and lock controller: loop-filter discharge, 5-bit SAR band search,
// settle, windowed frequency tracking, lock supervision with bounded relock retries.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int WIN        = WIN_DEF,
    parameter int TARGET     = TARGET_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int LOSS_TOL   = LOSS_TOL_DEF,
    parameter int LOCK_WINS  = LOCK_WINS_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int RST_CYC    = RST_CYC_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       fb_tick,
    input  logic       up,
    input  logic       down,
    output logic       cp_en,
    output logic       lpf_rst,
    output logic [4:0] band,
    output logic       lock,
    output logic       busy,
    output logic       fail,
    output state_e     state
);

    localparam logic [CNT_W-1:0]  TARGET_C    = CNT_W'(TARGET);
    localparam logic [CNT_W-1:0]  ACT_LIM     = CNT_W'(WIN / 8);
    localparam logic signed [10:0] TARGET_S   = 11'(TARGET);
    localparam logic signed [10:0] TOL_S      = 11'(TOL);
    localparam logic signed [10:0] LOSS_S     = 11'(LOSS_TOL);
    localparam logic [7:0]        RST_LAST    = 8'(RST_CYC - 1);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]        LOCK_C      = 4'(LOCK_WINS);
    localparam logic [3:0]        RETRY_C     = 4'(MAX_RETRY);
    localparam logic [5:0]        TRACK_LAST  = 6'(TRACK_WINS - 1);
    localparam logic [2:0]        SAR_DONE    = 3'd7;

    state_e     state_nx;
    logic [4:0] band_nx;
    logic [2:0] bit_idx, bit_nx;
    logic       gap, gap_nx;
    logic [3:0] retry, retry_nx;
    logic [7:0] cyc, cyc_nx;
    logic [3:0] good, good_nx;
    logic [5:0] twin, twin_nx;
    logic       retry_req;

    logic              m_clr;
    logic              m_done;
    logic [CNT_W-1:0]  m_count;
    logic [CNT_W-1:0]  m_act;
    logic signed [10:0] diff;
    logic signed [10:0] err;
    logic              win_good;

    // The gap cycle after each SAR window lets the new band take effect before measuring.
    assign m_clr = abort || gap || !((state == COARSE) || (state == TRACK) || (state == LOCKED));

    freq_window_meter #(.WIN(WIN)) u_meter (
        .clk       (refclk),
        .rst       (rst),
        .clr       (m_clr),
        .fb_tick   (fb_tick),
        .act       (up | down),
        .done      (m_done),
        .count     (m_count),
        .act_count (m_act)
    );

    always_comb begin
        diff     = $signed({1'b0, m_count}) - TARGET_S;
        err      = diff[10] ? -diff : diff;
        win_good = (err <= TOL_S) && (m_act < ACT_LIM);
    end

    always_comb begin
        state_nx  = state;
        band_nx   = band;
        bit_nx    = bit_idx;
        gap_nx    = 1'b0;
        retry_nx  = retry;
        cyc_nx    = cyc;
        good_nx   = good;
        twin_nx   = twin;
        retry_req = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx = LPF_RST;
                        retry_nx = '0;
                        cyc_nx   = '0;
                    end
                end
                LPF_RST: begin
                    if (cyc == RST_LAST) begin
                        state_nx = COARSE;
                        band_nx  = BAND_INIT;
                        bit_nx   = 3'd4;
                    end else begin
                        cyc_nx = cyc + 8'd1;
                    end
                end
                COARSE: begin
                    if (gap) begin
                        if (bit_idx == SAR_DONE) begin
                            state_nx = SETTLE;
                            cyc_nx   = '0;
                        end
                    end else if (m_done) begin
                        // Resolve the trial bit, then arm the next lower one.
                        for (int i = 0; i < 5; i++) begin
                            if ((bit_idx == 3'(i)) && (m_count >= TARGET_C)) band_nx[i] = 1'b0;
                            if (bit_idx == 3'(i + 1)) band_nx[i] = 1'b1;
                        end
                        bit_nx = bit_idx - 3'd1;
                        gap_nx = 1'b1;
                    end
                end
                SETTLE: begin
                    if (cyc == SETTLE_LAST) begin
                        state_nx = TRACK;
                        good_nx  = '0;
                        twin_nx  = '0;
                    end else begin
                        cyc_nx = cyc + 8'd1;
                    end
                end
                TRACK: begin
                    if (m_done) begin
                        twin_nx = twin + 6'd1;
                        if (win_good) begin
                            good_nx = good + 4'd1;
                            if (good + 4'd1 == LOCK_C) state_nx = LOCKED;
                        end else begin
                            good_nx = '0;
                        end
                        if ((state_nx != LOCKED) && (twin == TRACK_LAST)) retry_req = 1'b1;
                    end
                end
                LOCKED: begin
                    if (m_done && (err > LOSS_S)) retry_req = 1'b1;
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: state_nx = IDLE;
            endcase
            if (retry_req) begin
                if (retry < RETRY_C) begin
                    retry_nx = retry + 4'd1;
                    state_nx = LPF_RST;
                    cyc_nx   = '0;
                end else begin
                    state_nx = FAIL;
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state   <= IDLE;
            band    <= BAND_INIT;
            bit_idx <= '0;
            gap     <= 1'b0;
            retry   <= '0;
            cyc     <= '0;
            good    <= '0;
            twin    <= '0;
            cp_en   <= 1'b0;
            lpf_rst <= 1'b0;
            lock    <= 1'b0;
            busy    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state   <= state_nx;
            band    <= band_nx;
            bit_idx <= bit_nx;
            gap     <= gap_nx;
            retry   <= retry_nx;
            cyc     <= cyc_nx;
            good    <= good_nx;
            twin    <= twin_nx;
            cp_en   <= (state_nx == SETTLE) || (state_nx == TRACK) || (state_nx == LOCKED);
            lpf_rst <= (state_nx == LPF_RST);
            lock    <= (state_nx == LOCKED);
            busy    <= (state_nx == LPF_RST) || (state_nx == COARSE) ||
                       (state_nx == SETTLE) || (state_nx == TRACK);
            fail    <= (state_nx == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: oscillator model driven by band, scoreboard of expected
// durations/band codes, and a standalone window meter for the edge-tick cases.
module tb_pll_lock_ctrl;
    import pll_ctrl_pkg::*;

    logic       refclk = 1'b0;
    logic       rst, start, abort, fb_tick, up, down;
    logic       cp_en, lpf_rst, lock, busy, fail;
    logic [4:0] band;
    state_e     state;

    logic       m_clr, m_tick, m_act_in, m_done;
    logic [9:0] m_count, m_act;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] exp_q[$];

    int rate_fixed = 0;
    int fixed_n    = 0;
    int up_len     = 0;
    int lpf_rises  = 0;
    logic lpf_q    = 1'b0;

    pll_lock_ctrl dut (
        .refclk  (refclk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .fb_tick (fb_tick),
        .up      (up),
        .down    (down),
        .cp_en   (cp_en),
        .lpf_rst (lpf_rst),
        .band    (band),
        .lock    (lock),
        .busy    (busy),
        .fail    (fail),
        .state   (state)
    );

    freq_window_meter #(.WIN(16)) u_meter (
        .clk       (refclk),
        .rst       (rst),
        .clr       (m_clr),
        .fb_tick   (m_tick),
        .act       (m_act_in),
        .done      (m_done),
        .count     (m_count),
        .act_count (m_act)
    );

    // ---------------- clock ----------------
    always #5 refclk = ~refclk;

    // Oscillator/PFD model: N ticks spread evenly over every 256 cycles, so any
    // full window sees exactly N while N is constant.
    initial begin
        int n;
        int acc;
        int phase;
        acc = 0;
        phase = 0;
        fb_tick = 1'b0;
        up = 1'b0;
        forever begin
            @(posedge refclk);
            cyc++;
            #1;
            n = (rate_fixed != 0) ? fixed_n : 200 + 2 * int'(band);
            acc += n;
            if (acc >= 256) begin
                fb_tick = 1'b1;
                acc -= 256;
            end else begin
                fb_tick = 1'b0;
            end
            up = (phase < up_len);
            phase = (phase + 1) % 256;
        end
    end

    initial begin
        forever begin
            @(negedge refclk);
            if (lpf_rst && !lpf_q) lpf_rises++;
            lpf_q = lpf_rst;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        exp = 32'hffff_ffff;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        check_eq(tag, got, exp);
    endtask

    function automatic logic [4:0] sar_ref(input int steps, input int use_fixed, input int n_fixed);
        logic [4:0] b;
        int bi;
        int n;
        b = 5'b10000;
        for (int k = 0; k < steps; k++) begin
            bi = 4 - k;
            n = (use_fixed != 0) ? n_fixed : 200 + 2 * int'(b);
            if (n >= 230) b[bi] = 1'b0;
            if (bi > 0) b[bi-1] = 1'b1;
        end
        return b;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge refclk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge refclk);
        abort = 1'b0;
    endtask

    task automatic wait_state(input state_e st, input int budget, input string tag, output int t);
        int n;
        n = 0;
        while (state != st && n < budget) begin
            @(negedge refclk);
            n++;
        end
        check_eq(tag, 32'(state), 32'(st));
        t = cyc;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t0, t1, t2, t3, t4, n, r0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; down = 1'b0;
        m_clr = 1'b0; m_tick = 1'b0; m_act_in = 1'b0;
        repeat (3) @(negedge refclk);

        check_eq("rst_flags", 32'({cp_en, lpf_rst, lock, busy, fail}), 32'd0);
        check_eq("rst_band", 32'(band), 32'd16);
        check_eq("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        @(negedge refclk);

        // Edge ticks on a 16-cycle meter: last cycle of window 0 and first of window 1.
        m_clr = 1'b1;
        @(negedge refclk);
        m_clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_tick   = (i == 15 || i == 16);
            m_act_in = (i >= 2 && i <= 4);
            if (i == 15) begin exp_q.push_back(1); exp_q.push_back(3); end
            if (i == 31) begin exp_q.push_back(1); exp_q.push_back(0); end
            #1;
            if (i == 15 || i == 31) begin
                check_eq("mtr_done", 32'(m_done), 32'd1);
                sb_pop("mtr_edge_cnt", 32'(m_count));
                sb_pop("mtr_act_cnt", 32'(m_act));
            end else if (i == 14 || i == 16) begin
                check_eq("mtr_no_done", 32'(m_done), 32'd0);
            end
            @(negedge refclk);
        end
        m_tick = 1'b0;
        m_act_in = 1'b0;

        // Nominal acquisition with ticks/window = 200 + 2*band.
        rate_fixed = 0;
        up_len = 0;
        exp_q.push_back(16);
        exp_q.push_back(5 * 256 + 5);
        exp_q.push_back(32'(sar_ref(5, 0, 0)));
        exp_q.push_back(64);
        exp_q.push_back(4 * 256);
        pulse_start();
        wait_state(LPF_RST, 4, "nom_lpf_state", t0);
        check_eq("nom_lpf_out", 32'({lpf_rst, cp_en, busy}), 32'b101);
        wait_state(COARSE, 40, "nom_coarse_state", t1);
        sb_pop("nom_lpf_len", 32'(t1 - t0));
        check_eq("nom_coarse_cp", 32'({cp_en, lpf_rst, busy}), 32'b001);
        wait_state(SETTLE, 1400, "nom_settle_state", t2);
        sb_pop("nom_coarse_len", 32'(t2 - t1));
        sb_pop("nom_band", 32'(band));
        check_eq("nom_settle_cp", 32'(cp_en), 32'd1);
        wait_state(TRACK, 100, "nom_track_state", t3);
        sb_pop("nom_settle_len", 32'(t3 - t2));
        wait_state(LOCKED, 1100, "nom_locked_state", t4);
        sb_pop("nom_lock_delay", 32'(t4 - t3));
        check_eq("nom_lock_flags", 32'({lock, busy, cp_en, fail}), 32'b1010);

        // Loss of lock: exactly one window at count 240.
        repeat (255) @(negedge refclk);
        fixed_n = 240;
        rate_fixed = 1;
        exp_q.push_back(16);
        exp_q.push_back(32'(sar_ref(5, 0, 0)));
        repeat (256) @(negedge refclk);
        check_eq("loss_hold", 32'(lock), 32'd1);
        rate_fixed = 0;
        @(negedge refclk);
        check_eq("loss_drop", 32'({lock, lpf_rst}), 32'b01);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (lpf_rst) n++;
            @(negedge refclk);
        end
        sb_pop("loss_lpf_len", 32'(n));
        wait_state(LOCKED, 3000, "relock_state", t0);
        sb_pop("relock_band", 32'(band));

        // Reset while locked.
        rst = 1'b1;
        @(negedge refclk);
        check_eq("lrst_flags", 32'({cp_en, lpf_rst, lock, busy, fail}), 32'd0);
        check_eq("lrst_band", 32'(band), 32'd16);
        check_eq("lrst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        @(negedge refclk);

        // Abort during the bit-2 trial window.
        exp_q.push_back(32'(sar_ref(2, 0, 0)));
        exp_q.push_back(32'(sar_ref(2, 0, 0)));
        pulse_start();
        wait_state(COARSE, 40, "ab_coarse_state", t0);
        repeat (2 * 257 + 20) @(negedge refclk);
        sb_pop("ab_band_pre", 32'(band));
        pulse_abort();
        check_eq("ab_state", 32'(state), 32'(IDLE));
        sb_pop("ab_band_hold", 32'(band));
        check_eq("ab_busy", 32'(busy), 32'd0);

        // Phase activity of 40 cycles/window must block lock.
        up_len = 40;
        exp_q.push_back(0);
        pulse_start();
        wait_state(TRACK, 1500, "ph_track_state", t0);
        n = 0;
        for (int i = 0; i < 8 * 256; i++) begin
            if (lock || state == LOCKED) n++;
            @(negedge refclk);
        end
        sb_pop("ph_nolock", 32'(n));
        pulse_abort();
        up_len = 0;

        // Low count: band saturates high, then fails after all retries.
        rate_fixed = 1;
        fixed_n = 100;
        exp_q.push_back(32'(sar_ref(5, 1, 100)));
        exp_q.push_back(32'(sar_ref(5, 1, 100)));
        exp_q.push_back(4);
        r0 = lpf_rises;
        pulse_start();
        wait_state(SETTLE, 1500, "lo_settle_state", t0);
        sb_pop("lo_band", 32'(band));
        wait_state(TRACK, 100, "lo_track_state", t0);
        wait_state(FAIL, 40000, "lo_fail_state", t1);
        check_eq("lo_fail_flags", 32'({fail, busy, cp_en, lock, lpf_rst}), 32'b10000);
        sb_pop("lo_band_hold", 32'(band));
        sb_pop("lo_attempts", 32'(lpf_rises - r0));
        pulse_start();
        @(negedge refclk);
        check_eq("lo_fail_sticky", 32'(state), 32'(FAIL));
        pulse_abort();
        check_eq("lo_abort_exit", 32'({state == IDLE, fail}), 32'b10);

        // High count: every trial bit is cleared.
        fixed_n = 256;
        exp_q.push_back(32'(sar_ref(5, 1, 256)));
        pulse_start();
        wait_state(SETTLE, 1500, "hi_settle_state", t0);
        sb_pop("hi_band", 32'(band));
        wait_state(TRACK, 100, "hi_track_state", t0);
        pulse_abort();
        rate_fixed = 0;

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
